// File: rtl/ws2812_rx.sv
// WS2812 single-wire stream receiver.
// Measures high-pulse widths on a synchronised din to recover bits.
// Packs them MSB-first into 24-bit pixel words tagged with their frame position.
// A long low gap closes the frame and reports the word count.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_GAP  | resynchronising: wait for RESET_CYCLES of continuous low
// S_IDLE | between frames, line low, waiting for the first rising edge
// S_HIGH | measuring the current high pulse
// S_LOW  | measuring the low time after a bit; a long low ends the frame
module ws2812_rx #(
  parameter int BIT_THRESH   = 7,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 20,
  parameter int RESET_CYCLES = 600,
  parameter int NUM_LEDS     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic [7:0]  pixel_index,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        overflow,
  output logic        error
);

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int CW = $clog2(RESET_CYCLES + 1);

  localparam logic [HW-1:0] BIT_THRESH_C = HW'(BIT_THRESH);
  localparam logic [HW-1:0] MIN_HIGH_C   = HW'(MIN_HIGH);
  localparam logic [HW-1:0] MAX_HIGH_C   = HW'(MAX_HIGH);
  localparam logic [CW-1:0] LOW_LAST_C   = CW'(RESET_CYCLES - 1);
  localparam logic [8:0]    NUM_LEDS_C   = 9'(NUM_LEDS);

  typedef enum logic [1:0] {
    S_GAP  = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  state_t        state_q;
  logic          s1_q, s2_q, s3_q;
  logic [HW-1:0] high_cnt_q;
  logic [CW-1:0] low_cnt_q;
  logic [4:0]    bit_cnt_q;
  logic [7:0]    word_cnt_q;
  logic [22:0]   shift_q;

  logic          rise;
  logic          fall;
  logic          bit_d;
  logic [23:0]   shift_d;
  logic          word_in_range;
  logic          word_over;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise          = s2_q & ~s3_q;
  assign fall          = ~s2_q & s3_q;
  assign bit_d         = (high_cnt_q >= BIT_THRESH_C);
  assign shift_d       = {shift_q, bit_d};
  assign word_in_range = ({1'b0, word_cnt_q} < NUM_LEDS_C);
  assign word_over     = ({1'b0, word_cnt_q} > NUM_LEDS_C);

  // Decoder FSM; all outputs are registered here, strobes default low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_GAP;
      high_cnt_q  <= '0;
      low_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      shift_q     <= '0;
      pixel_data  <= '0;
      pixel_index <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
      error       <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      case (state_q)
        S_GAP: begin
          // Any high restarts the quiet-time count; pulses are otherwise ignored.
          if (s2_q) begin
            low_cnt_q <= '0;
          end else if (low_cnt_q == LOW_LAST_C) begin
            low_cnt_q <= '0;
            state_q   <= S_IDLE;
          end else begin
            low_cnt_q <= low_cnt_q + CW'(1);
          end
        end

        S_IDLE: begin
          if (rise) begin
            high_cnt_q <= HW'(1);
            state_q    <= S_HIGH;
          end
        end

        S_HIGH: begin
          if (high_cnt_q > MAX_HIGH_C) begin
            // Stuck-high or far too long a pulse: abandon the frame.
            error      <= 1'b1;
            low_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            state_q    <= S_GAP;
          end else if (s2_q) begin
            // Never exceeds MAX_HIGH+1 since the branch above catches it first.
            high_cnt_q <= high_cnt_q + HW'(1);
          end else if (fall) begin
            if (high_cnt_q < MIN_HIGH_C) begin
              error      <= 1'b1;
              low_cnt_q  <= '0;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              shift_q    <= '0;
              state_q    <= S_GAP;
            end else begin
              shift_q <= shift_d[22:0];
              if (bit_cnt_q == 5'd23) begin
                bit_cnt_q   <= '0;
                pixel_data  <= shift_d;
                pixel_index <= word_cnt_q;
                pixel_valid <= word_in_range;
                if (word_cnt_q != 8'hFF) begin
                  word_cnt_q <= word_cnt_q + 8'd1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
              low_cnt_q <= CW'(1);
              state_q   <= S_LOW;
            end
          end
        end

        S_LOW: begin
          if (rise) begin
            high_cnt_q <= HW'(1);
            state_q    <= S_HIGH;
          end else if (!s2_q) begin
            if (low_cnt_q == LOW_LAST_C) begin
              // Frame ends; a half-built word is reported as an error and dropped.
              error       <= (bit_cnt_q != 5'd0);
              frame_done  <= 1'b1;
              frame_count <= word_cnt_q;
              overflow    <= word_over;
              word_cnt_q  <= '0;
              bit_cnt_q   <= '0;
              shift_q     <= '0;
              low_cnt_q   <= '0;
              state_q     <= S_IDLE;
            end else begin
              low_cnt_q <= low_cnt_q + CW'(1);
            end
          end
        end

        default: begin
          state_q <= S_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives din pulse trains from bit lists.
// A run-length model of the line predicts every output cycle by cycle.
// Directed frames also pin the model with literal results.
module tb_ws2812_rx;

  localparam int BIT_THRESH   = 7;
  localparam int MIN_HIGH     = 2;
  localparam int MAX_HIGH     = 20;
  localparam int RESET_CYCLES = 600;
  localparam int NUM_LEDS     = 8;

  localparam int M_GAP   = 0;
  localparam int M_IDLE  = 1;
  localparam int M_FRAME = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic [7:0]  pixel_index;
  logic        pixel_valid;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        overflow;
  logic        error;

  ws2812_rx dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .pixel_data  (pixel_data),
    .pixel_index (pixel_index),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .overflow    (overflow),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pv;
    logic        latch;
    logic        fd;
    logic        err;
    logic        ovf;
    logic [23:0] data;
    logic [7:0]  idx;
    logic [7:0]  fcnt;
  } ev_t;

  ev_t evq [int];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rst_now = 1'b1;

  // line model state
  int mode = M_GAP;
  logic prev = 1'b0;
  int hlen = 0, llen = 0, gaplow = 0, bits = 0, words = 0;
  logic [23:0] acc = '0;

  // expected held outputs
  logic [23:0] h_pd = '0;
  logic [7:0]  h_pi = '0, h_fc = '0;
  logic        h_ovf = 1'b0;

  // tallies of observed strobes for literal checks
  int n_pv = 0, n_fd = 0, n_err = 0;
  logic [23:0] l_pd = '0;
  logic [7:0]  l_pi = '0, l_fc = '0;
  logic        l_ovf = 1'b0;

  logic txq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic post(input int k, input ev_t e);
    if (evq.exists(k)) evq[k] = ev_t'(evq[k] | e);
    else evq[k] = e;
  endtask

  task automatic model_step(input logic d);
    ev_t e;
    e = '0;
    case (mode)
      M_GAP: begin
        if (d) gaplow = 0;
        else begin
          gaplow++;
          if (gaplow >= RESET_CYCLES) mode = M_IDLE;
        end
      end
      M_IDLE: begin
        if (d) begin
          mode = M_FRAME;
          hlen = 1;
        end
      end
      default: begin
        if (d) begin
          if (prev) hlen++;
          else hlen = 1;
          if (hlen == MAX_HIGH + 1) begin
            e.err = 1'b1;
            post(cyc + 3, e);
            mode = M_GAP; gaplow = 0; bits = 0; words = 0;
          end
        end else if (prev) begin
          if (hlen < MIN_HIGH) begin
            e.err = 1'b1;
            post(cyc + 2, e);
            mode = M_GAP; gaplow = 0; bits = 0; words = 0;
          end else begin
            acc = {acc[22:0], (hlen >= BIT_THRESH)};
            bits++;
            if (bits == 24) begin
              e.latch = 1'b1;
              e.data  = acc;
              e.idx   = 8'(words);
              e.pv    = (words < NUM_LEDS);
              post(cyc + 2, e);
              bits = 0;
              if (words < 255) words++;
            end
            llen = 1;
          end
        end else begin
          llen++;
          if (llen == RESET_CYCLES) begin
            e.fd   = 1'b1;
            e.fcnt = 8'(words);
            e.ovf  = (words > NUM_LEDS);
            e.err  = (bits != 0);
            post(cyc + 2, e);
            words = 0; bits = 0;
            mode = M_IDLE;
          end
        end
      end
    endcase
    prev = d;
  endtask

  // Model: consume one din sample per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rst_now = reset;
      if (reset) begin
        for (int k = cyc; k <= cyc + 3; k++) if (evq.exists(k)) evq.delete(k);
        mode = M_GAP; prev = 1'b0; gaplow = 0; bits = 0; words = 0;
        hlen = 0; llen = 0; acc = '0;
      end else begin
        model_step(din);
      end
    end
  end

  // Compare every output mid-cycle against the model.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_now) begin
        h_pd = '0; h_pi = '0; h_fc = '0; h_ovf = 1'b0;
      end
      e = '0;
      if (evq.exists(cyc)) begin
        e = evq[cyc];
        evq.delete(cyc);
      end
      if (e.latch) begin h_pd = e.data; h_pi = e.idx; end
      if (e.fd) begin h_fc = e.fcnt; h_ovf = e.ovf; end
      chk("pixel_valid", 32'(pixel_valid), 32'(e.pv));
      chk("frame_done",  32'(frame_done),  32'(e.fd));
      chk("error",       32'(error),       32'(e.err));
      chk("pixel_data",  32'(pixel_data),  32'(h_pd));
      chk("pixel_index", 32'(pixel_index), 32'(h_pi));
      chk("frame_count", 32'(frame_count), 32'(h_fc));
      chk("overflow",    32'(overflow),    32'(h_ovf));
      if (pixel_valid) begin n_pv++; l_pd = pixel_data; l_pi = pixel_index; end
      if (frame_done) begin n_fd++; l_fc = frame_count; l_ovf = overflow; end
      if (error) n_err++;
    end
  end

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_bits(input logic [23:0] w, input int skip, input int nb);
    for (int i = skip; i < skip + nb; i++) txq.push_back(w[23 - i]);
  endtask

  task automatic push_word(input logic [23:0] w);
    push_bits(w, 0, 24);
  endtask

  // wmode 0: nominal 5/10 widths, 1: random legal widths, 2: threshold extremes
  task automatic flush(input int gap, input int wmode, input int err_pos, input int err_w);
    int n;
    n = txq.size();
    for (int i = 0; i < n; i++) begin
      int h, l;
      if (wmode == 1) begin
        h = txq[i] ? int'($urandom_range(20, 7)) : int'($urandom_range(6, 2));
        l = int'($urandom_range(20, 2));
      end else if (wmode == 2) begin
        h = txq[i] ? ((i % 2) ? 20 : 7) : ((i % 2) ? 6 : 2);
        l = 2;
      end else begin
        h = txq[i] ? 10 : 5;
        l = txq[i] ? 5 : 10;
      end
      if (i == err_pos) h = err_w;
      if (i == n - 1) l = gap;
      drive(1'b1, h);
      drive(1'b0, l);
    end
    txq.delete();
  endtask

  task automatic clr_tally();
    n_pv = 0; n_fd = 0; n_err = 0;
  endtask

  initial begin
    logic [23:0] t2 [8];
    logic [31:0] r;
    t2 = '{24'h100000, 24'h001000, 24'h000010, 24'h101000,
           24'h001010, 24'h100010, 24'h000000, 24'h101010};

    reset = 1'b1;
    din = 1'b0;
    drive(1'b0, 5);
    reset = 1'b0;
    drive(1'b0, 700);

    // single pixel
    clr_tally();
    push_word(24'hA53C0F);
    flush(700, 0, -1, 0);
    chk("t1_pv_count", 32'(n_pv), 1);
    chk("t1_data", 32'(l_pd), 32'h00A53C0F);
    chk("t1_index", 32'(l_pi), 0);
    chk("t1_fd_count", 32'(n_fd), 1);
    chk("t1_fcount", 32'(l_fc), 1);
    chk("t1_ovf", 32'(l_ovf), 0);
    chk("t1_err", 32'(n_err), 0);

    // eight pixels
    clr_tally();
    for (int i = 0; i < 8; i++) push_word(t2[i]);
    flush(700, 0, -1, 0);
    chk("t2_pv_count", 32'(n_pv), 8);
    chk("t2_last_data", 32'(l_pd), 32'h00101010);
    chk("t2_last_index", 32'(l_pi), 7);
    chk("t2_fcount", 32'(l_fc), 8);
    chk("t2_ovf", 32'(l_ovf), 0);

    // ten pixels overflow, then a one-pixel frame clears overflow
    clr_tally();
    for (int i = 0; i < 10; i++) push_word(24'(i * 24'h030201 + 1));
    flush(700, 0, -1, 0);
    chk("t3_pv_count", 32'(n_pv), 8);
    chk("t3_fcount", 32'(l_fc), 10);
    chk("t3_ovf", 32'(l_ovf), 1);
    push_word(24'h00FF00);
    flush(700, 0, -1, 0);
    chk("t3b_fcount", 32'(l_fc), 1);
    chk("t3b_ovf", 32'(l_ovf), 0);
    chk("t3b_data", 32'(l_pd), 32'h0000FF00);

    // 12 bits then a gap
    clr_tally();
    push_bits(24'hF0F0F0, 0, 12);
    flush(700, 0, -1, 0);
    chk("t4_pv_count", 32'(n_pv), 0);
    chk("t4_err", 32'(n_err), 1);
    chk("t4_fd_count", 32'(n_fd), 1);
    chk("t4_fcount", 32'(l_fc), 0);

    // long pulse mid-word, then a clean frame
    clr_tally();
    push_word(24'h123456);
    push_word(24'h654321);
    flush(700, 0, 5, 25);
    chk("t5_err", 32'(n_err), 1);
    chk("t5_fd_count", 32'(n_fd), 0);
    chk("t5_pv_count", 32'(n_pv), 0);
    push_word(24'h5A5A5A);
    flush(700, 0, -1, 0);
    chk("t5b_pv_count", 32'(n_pv), 1);
    chk("t5b_data", 32'(l_pd), 32'h005A5A5A);
    chk("t5b_fcount", 32'(l_fc), 1);

    // reset mid-frame while the stream continues
    clr_tally();
    push_bits(24'hABCDEF, 0, 10);
    flush(10, 0, -1, 0);
    reset = 1'b1;
    push_bits(24'hABCDEF, 10, 1);
    flush(5, 0, -1, 0);
    reset = 1'b0;
    push_bits(24'hABCDEF, 11, 13);
    push_word(24'h777777);
    flush(700, 0, -1, 0);
    chk("t6_pv_count", 32'(n_pv), 0);
    chk("t6_fd_count", 32'(n_fd), 0);
    chk("t6_err", 32'(n_err), 0);
    push_word(24'hC3C3C3);
    flush(700, 0, -1, 0);
    chk("t6b_pv_count", 32'(n_pv), 1);
    chk("t6b_index", 32'(l_pi), 0);
    chk("t6b_data", 32'(l_pd), 32'h00C3C3C3);

    // threshold-extreme widths (2/6 as 0, 7/20 as 1)
    clr_tally();
    push_word(24'hF0F0F0);
    flush(700, 2, -1, 0);
    chk("t7_data", 32'(l_pd), 32'h00F0F0F0);
    chk("t7_err", 32'(n_err), 0);

    // 599-cycle low inside a word, then exactly 600 low before the next frame
    clr_tally();
    push_bits(24'h3C3C3C, 0, 12);
    flush(599, 0, -1, 0);
    push_bits(24'h3C3C3C, 12, 12);
    flush(600, 0, -1, 0);
    push_word(24'h0F0F0F);
    flush(700, 0, -1, 0);
    chk("t8_pv_count", 32'(n_pv), 2);
    chk("t8_fd_count", 32'(n_fd), 2);
    chk("t8_err", 32'(n_err), 0);
    chk("t8_data", 32'(l_pd), 32'h000F0F0F);
    chk("t8_index", 32'(l_pi), 0);

    // randomized frames, some with partial words or bad pulses
    for (int f = 0; f < 10; f++) begin
      int np, sz, ep, ew, gap;
      np = int'($urandom_range(10, 0));
      for (int p = 0; p < np; p++) begin
        r = $urandom();
        push_word(r[23:0]);
      end
      if ($urandom_range(3, 0) == 0) begin
        r = $urandom();
        push_bits(r[23:0], 0, int'($urandom_range(23, 1)));
      end
      sz = txq.size();
      ep = -1;
      ew = 0;
      if (sz > 0 && $urandom_range(3, 0) == 0) begin
        ep = int'($urandom_range(sz - 1, 0));
        ew = ($urandom_range(1, 0) == 0) ? 1 : int'($urandom_range(25, 21));
      end
      gap = (ep >= 0) ? int'($urandom_range(800, 650)) : int'($urandom_range(800, 600));
      if (sz > 0) flush(gap, 1, ep, ew);
      else drive(1'b0, 50);
    end
    drive(1'b0, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

WS2812 stream receiver: samples a single-wire WS2812 data line, measures high-pulse widths to recover bits, and assembles 24-bit pixel words in wire order (first received bit is bit 23), tagged with their position in the frame. A low gap of at least RESET_CYCLES terminates the frame and reports the pixel count. It sits on a pmod input as the counterpart of the ws2812 transmitter: loopback self-test of LED frames, or sniffing an external LED chain.

## Interface
- CLK parameters assume 12 MHz; all in clock cycles.
- BIT_THRESH, 7: minimum high width (cycles) decoded as a 1; shorter decodes as 0.
- MIN_HIGH, 2: high pulses shorter than this are glitches and count as errors.
- MAX_HIGH, 20: high pulses longer than this are errors.
- RESET_CYCLES, 600: low time that ends a frame (50 us).
- NUM_LEDS, 8: pixel words per frame that are delivered.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- din  in  1  asynchronous WS2812 data line.
- pixel_data  out  24  last decoded word, wire order, bit 23 first received.
- pixel_index  out  8  frame position of pixel_data, 0-based.
- pixel_valid  out  1  one-cycle strobe, pixel_data/pixel_index valid.
- frame_done  out  1  one-cycle strobe at end of frame.
- frame_count  out  8  words received in the frame just ended, saturating at 255; valid with frame_done, held afterwards.
- overflow  out  1  set with frame_done if frame_count > NUM_LEDS; cleared by the next frame_done without overflow.
- error  out  1  one-cycle strobe on a decoding error.

## Operation
- din passes through two flops (s1, s2); s3 is the previous s2. rise = s2 & !s3, fall = !s2 & s3. All decoding uses s2 only.
- States: GAP, IDLE, HIGH, LOW.
- GAP: wait for s2 low for RESET_CYCLES consecutive cycles, then go to IDLE with no outputs. Entered after reset and after any error. Pulses in GAP are ignored.
- IDLE: line low between frames. On rise, go to HIGH with high_cnt = 1.
- HIGH: high_cnt increments each cycle s2 is high, saturating at MAX_HIGH+1. If high_cnt exceeds MAX_HIGH, pulse error, discard the partial word and go to GAP. On fall:
  - If high_cnt < MIN_HIGH, pulse error and go to GAP.
  - Otherwise shift in bit = (high_cnt >= BIT_THRESH) at the LSB and increment bit_cnt (0..23).
  - At the 24th bit, register pixel_data and pixel_index = word_cnt, and pulse pixel_valid only if word_cnt < NUM_LEDS. word_cnt increments, saturating at 255. bit_cnt wraps to 0.
  - Then go to LOW with low_cnt = 1.
- LOW: low_cnt increments each cycle s2 is low. On rise, go to HIGH.
- End of frame (low_cnt reaches RESET_CYCLES):
  - If bit_cnt != 0, pulse error and drop the partial bits.
  - Pulse frame_done and load frame_count = word_cnt and overflow = (word_cnt > NUM_LEDS).
  - Clear word_cnt and bit_cnt, then go to IDLE.
- Errors never produce frame_done; the frame in progress is abandoned.
- Reset values: pixel_data 0, pixel_index 0, pixel_valid 0, frame_done 0, frame_count 0, overflow 0, error 0. State is GAP, all counters 0, sync flops 0.
- Reset mid-frame aborts the frame silently; remaining pulses are absorbed by GAP.

## Timing
- e0 is the first clk edge at which din is sampled low after the 24th high pulse. pixel_valid is high for the one cycle after edge e0+2.
- High width is measured as the number of edges at which din is sampled high, exact to ±1 cycle of din asynchrony.
- frame_done: e0 is the first edge sampling din low after the last pulse. frame_done is high for the one cycle after edge e0+RESET_CYCLES+1.
- error fires in the cycle after fall, or after high_cnt exceeds MAX_HIGH, or together with frame_done's cycle for a partial word.
- pixel_valid and frame_done are never high in the same cycle.
- Minimum bit period is 2×MIN_HIGH cycles; no throughput stall.

## Test plan
- Single pixel 24'hA5_3C_0F from reset after a 700-cycle low. 0 bits are 5 high/10 low cycles, 1 bits are 10 high/5 low, then 700 low. Expect exactly one pixel_valid with data A53C0F, index 0; then frame_done, frame_count 1, overflow 0, no error.
- Eight pixels 0x100000, 0x001000, ... and 0x101010. Expect pixel_valid ×8 with index 0..7 and matching data, then frame_count 8.
- Ten pixels with NUM_LEDS 8. Expect 8 pixel_valid strobes, frame_count 10, overflow 1. Then a 1-pixel frame gives overflow 0.
- 12 bits then a 700-cycle gap. Expect no pixel_valid, an error strobe, frame_done with frame_count 0.
- A 25-cycle high pulse mid-word. Expect error, then no outputs for the rest of that frame. The following clean 1-pixel frame decodes correctly.
- Reset after 10 bits of a frame, released while the stream continues. Expect outputs at reset values and no pixel_valid until a 600-cycle gap. The next frame decodes with index 0.
